// File: rtl/irq_pending_latch.sv
// irq_pending_latch
// Request-capture stage in front of the 8-to-3 priority encoder. Rising edges on
// the raw request lines are held in a pending register until the encoder's index
// comes back through the ack handshake. The encoder sees pending & mask.
// Lines that re-fire while still pending set a sticky per-line overflow flag.
//
// Optional build macro IRQ_SYNC_EN: when defined, req passes through a 2-flop
// synchronizer (reset value all ones) before edge detection. Capture latency is
// then 3 clocks instead of 1. When undefined, req must be synchronous to clk.

module irq_pending_latch #(
  parameter int unsigned N    = 8,
  parameter int unsigned IDXW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    mask,
  input  logic            ack_valid,
  input  logic [IDXW-1:0] ack_idx,
  output logic [N-1:0]    pend_o,
  output logic            irq_o,
  output logic [N-1:0]    ovf_o,
  output logic            ack_err_o
);

  logic [N-1:0] req_s;      // request lines as seen by the edge detector
  logic [N-1:0] req_q;      // previous sample of req_s
  logic [N-1:0] edge_v;     // rising edges this cycle
  logic [N-1:0] set_v;      // edges that are allowed to capture
  logic [N-1:0] pending;
  logic [N-1:0] ovf;
  logic [N-1:0] ack_hit;    // one-hot decode of ack_idx (zero if out of range)
  logic [N-1:0] ack_clr;    // lines actually cleared by this ack
  logic         ack_ok;
  logic         ack_err;
  logic [N-1:0] pending_nxt;
  logic [N-1:0] ovf_nxt;

`ifdef IRQ_SYNC_EN
  logic [N-1:0] sync_1;
  logic [N-1:0] sync_2;

  // Two-flop synchronizer; resets high so lines held high at release stay quiet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '1;
      sync_2 <= '1;
    end else begin
      sync_1 <= req;
      sync_2 <= sync_1;
    end
  end

  assign req_s = sync_2;
`else
  assign req_s = req;
`endif

  // Previous-sample register; tracks every cycle regardless of en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '1;
    end else begin
      req_q <= req_s;
    end
  end

  assign edge_v = req_s & ~req_q;
  assign set_v  = en ? edge_v : '0;

  // Decode the ack index; indices at or above N match no line
  always_comb begin
    ack_hit = '0;
    for (int unsigned i = 0; i < N; i++) begin
      ack_hit[i] = ack_valid && (32'(ack_idx) == i);
    end
  end

  // An ack is accepted only when it names a line that is currently pending
  assign ack_ok  = |(ack_hit & pending);
  assign ack_clr = ack_ok ? ack_hit : '0;
  assign ack_err = ack_valid && !ack_ok;

  // Next-state: set wins over a same-cycle ack, and an acked line cannot overflow
  always_comb begin
    pending_nxt = (pending & ~ack_clr) | set_v;
    ovf_nxt     = (ovf & ~ack_clr) | (set_v & pending & ~ack_clr);
  end

  // Pending, overflow and ack-error state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      ovf       <= '0;
      ack_err_o <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      ovf       <= ovf_nxt;
      ack_err_o <= ack_err;
    end
  end

  // Masking is purely combinational so a mask change shows in the same cycle
  always_comb begin
    pend_o = pending & mask;
    irq_o  = |pend_o;
    ovf_o  = ovf;
  end

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch
// Directed scenarios for irq_pending_latch (default build, 1-clock capture latency).
// Each scenario pushes its expected outputs onto a scoreboard queue as it drives
// stimulus, then pops and compares once the DUT has had its clock edge.

module tb_irq_pending_latch;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack_valid;
  logic [2:0] ack_idx;
  logic [7:0] pend_o;
  logic       irq_o;
  logic [7:0] ovf_o;
  logic       ack_err_o;

  typedef struct {
    string      name;
    logic [7:0] pend;
    logic       irq;
    logic [7:0] ovf;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests  = 0;
  int   n_failed = 0;

  irq_pending_latch #(.N(8), .IDXW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .mask      (mask),
    .ack_valid (ack_valid),
    .ack_idx   (ack_idx),
    .pend_o    (pend_o),
    .irq_o     (irq_o),
    .ovf_o     (ovf_o),
    .ack_err_o (ack_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_failed + 1);
    $fatal(1);
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; req = 8'h00; mask = 8'hFF; ack_valid = 1'b0; ack_idx = 3'd0;
    sb.push_back('{"reset_state", 8'h00, 1'b0, 8'h00, 1'b0});
    tick(); tick();
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_capture();
    req[5] = 1'b1;
    sb.push_back('{"capture_req5", 8'h20, 1'b1, 8'h00, 1'b0});
    tick();
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
  endtask

  task automatic test_ack();
    ack_valid = 1'b1; ack_idx = 3'd5;
    sb.push_back('{"ack_idx5", 8'h00, 1'b0, 8'h00, 1'b0});
    tick();
    ack_valid = 1'b0; req[5] = 1'b0;
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    tick();
  endtask

  task automatic test_mask();
    mask = 8'hFE; req[0] = 1'b1;
    sb.push_back('{"masked_capture", 8'h00, 1'b0, 8'h00, 1'b0});
    tick();
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    mask = 8'hFF;
    sb.push_back('{"unmask_same_cycle", 8'h01, 1'b1, 8'h00, 1'b0});
    #1;
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    ack_valid = 1'b1; ack_idx = 3'd0; req[0] = 1'b0;
    sb.push_back('{"ack_idx0", 8'h00, 1'b0, 8'h00, 1'b0});
    tick();
    ack_valid = 1'b0;
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
  endtask

  task automatic test_back_to_back();
    req[3] = 1'b1;
    tick();
    req[3] = 1'b0;
    tick();
    // new edge on line 3 in the same cycle it is acked: set wins, no overflow
    req[3] = 1'b1; ack_valid = 1'b1; ack_idx = 3'd3;
    sb.push_back('{"set_wins_over_ack", 8'h08, 1'b1, 8'h00, 1'b0});
    tick();
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    ack_idx = 3'd2;
    sb.push_back('{"ack_idle_line_err", 8'h08, 1'b1, 8'h00, 1'b1});
    tick();
    ack_valid = 1'b0;
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    sb.push_back('{"ack_err_one_cycle", 8'h08, 1'b1, 8'h00, 1'b0});
    tick();
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    ack_valid = 1'b1; ack_idx = 3'd3; req[3] = 1'b0;
    tick();
    ack_valid = 1'b0;
  endtask

  task automatic test_multi();
    req = 8'h41;
    sb.push_back('{"multi_set", 8'h41, 1'b1, 8'h00, 1'b0});
    tick();
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    ack_valid = 1'b1; ack_idx = 3'd6; req = 8'h00;
    sb.push_back('{"ack_one_of_two", 8'h01, 1'b1, 8'h00, 1'b0});
    tick();
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    ack_idx = 3'd0;
    tick();
    ack_valid = 1'b0;
  endtask

  task automatic test_overflow_en();
    req[7] = 1'b1;
    tick();
    req[7] = 1'b0;
    tick();
    req[7] = 1'b1;
    sb.push_back('{"overflow_req7", 8'h80, 1'b1, 8'h80, 1'b0});
    tick();
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    ack_valid = 1'b1; ack_idx = 3'd7; req[7] = 1'b0;
    sb.push_back('{"ack_clears_ovf", 8'h00, 1'b0, 8'h00, 1'b0});
    tick();
    ack_valid = 1'b0;
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    en = 1'b0; req[1] = 1'b1;
    sb.push_back('{"en0_discards_edge", 8'h00, 1'b0, 8'h00, 1'b0});
    tick();
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    en = 1'b1;
    sb.push_back('{"en_rise_no_fire", 8'h00, 1'b0, 8'h00, 1'b0});
    tick(); tick();
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    req[1] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    req = 8'hFF;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.push_back('{"high_at_release", 8'h00, 1'b0, 8'h00, 1'b0});
    tick(); tick();
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    req[4] = 1'b0;
    tick();
    req[4] = 1'b1;
    sb.push_back('{"fresh_edge_req4", 8'h10, 1'b1, 8'h00, 1'b0});
    tick();
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    req[4] = 1'b0;
    tick();
    req[4] = 1'b1; ack_valid = 1'b1; ack_idx = 3'd0;
    sb.push_back('{"ovf_and_err_before_reset", 8'h10, 1'b1, 8'h10, 1'b1});
    tick();
    ack_valid = 1'b0;
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    rst_n = 1'b0;
    sb.push_back('{"async_reset_clears", 8'h00, 1'b0, 8'h00, 1'b0});
    #2;
    e = sb.pop_front(); n_tests++;
    if ({pend_o, irq_o, ovf_o, ack_err_o} !== {e.pend, e.irq, e.ovf, e.err}) begin
      n_failed++;
      $display("FAIL %s: got pend=%h irq=%b ovf=%h err=%b, want pend=%h irq=%b ovf=%h err=%b", e.name, pend_o, irq_o, ovf_o, ack_err_o, e.pend, e.irq, e.ovf, e.err);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_ack();
    test_mask();
    test_back_to_back();
    test_multi();
    test_overflow_en();
    test_reset_mid();
    if (sb.size() != 0) begin
      n_tests++;
      n_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
Upstream request-capture stage for the 8-to-3 priority encoder. It detects rising edges on 8 raw request lines and holds each event in a pending register until it is acknowledged. It presents the masked pending vector as the encoder's 8-bit input. The encoder's 3-bit index is returned through an ack handshake to clear the bit that has been serviced.

Parameters:
N, 8, number of request lines (encoder input width)
IDXW, 3, ack index width; must satisfy 2**IDXW >= N

Ports:
clk  in  1  system clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
en  in  1  capture enable; 0 = new edges ignored
req  in  N  raw request lines, level signals
mask  in  N  per-line enable; 1 = line visible downstream
ack_valid  in  1  ack strobe, one cycle per ack
ack_idx  in  IDXW  index of the line being acknowledged (encoder output)
pend_o  out  N  pending & mask; feeds encoder input
irq_o  out  1  OR-reduction of pend_o
ovf_o  out  N  per-line sticky overflow flag
ack_err_o  out  1  one-cycle pulse: ack to a line that is not pending

Behaviour:
- Reset (rst_n low, asynchronous):
  - pending = 0, ovf = 0, ack_err_o = 0.
  - req_q (previous-sample register) = all ones, so lines already high at reset release do not fire.
  - Outputs therefore: pend_o = 0, irq_o = 0, ovf_o = 0, ack_err_o = 0.
- Edge detect: edge = req & ~req_q. req_q <= req every cycle, independent of en.
- Capture: at the clock edge where edge[i] = 1 and en = 1, pending[i] <= 1.
  - Latency: pend_o[i] rises one clock after the first clock that samples req[i] high.
- Mask:
  - Capture ignores mask; masked events are held, not dropped.
  - pend_o = pending & mask, combinational from registers and mask, so a mask change is visible the same cycle.
  - irq_o = |pend_o.
- Ack:
  - At the clock edge where ack_valid = 1, pending[ack_idx] <= 0 and ovf[ack_idx] <= 0.
  - ack_idx >= N, or pending[ack_idx] = 0: no state change, and ack_err_o = 1 for the next cycle only.
  - Ack works regardless of en and mask.
- Overflow: edge[i] & en while pending[i] = 1 and not being acked in the same cycle -> ovf[i] <= 1 (sticky). ovf[i] is cleared only by an ack of line i or by reset.
- Simultaneous capture and ack on the same line:
  - Set wins: pending[i] stays 1, and ovf[i] is cleared by the ack.
  - The new event is not lost and is not counted as overflow.
- Multiple lines: any number of lines may set in one cycle. Ack clears exactly one line per cycle.
- en = 0: edges are discarded, not deferred. pending and ovf hold except for acks. req_q keeps tracking, so raising en while a line is high does not fire that line.
- Reset mid-operation clears all pending events. After release, only fresh rising edges capture.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: req passes through a 2-flop synchronizer (reset value all ones) before edge detection.
  - Capture latency becomes 3 clocks from the first clock that sees req high.
  - Pulses shorter than one clock may be missed.
- Undefined: req feeds edge detection directly (1-clock latency). req is assumed synchronous to clk.

Test Plan:
1. Reset, req=0x00, mask=0xFF, en=1; raise req[5] -> next cycle pend_o=0x20, irq_o=1, ovf_o=0x00.
2. From case 1: ack_valid=1, ack_idx=5 for one cycle -> pend_o=0x00, irq_o=0, ack_err_o=0.
3. mask=0xFE; rising edge on req[0] -> pend_o=0x00, irq_o=0. Then mask=0xFF -> pend_o=0x01 in the same cycle.
4. pending[3]=1; new edge on req[3] in the same cycle as ack_valid=1, ack_idx=3 -> pend_o[3] stays 1, ovf_o[3]=0. Idle ack_idx=2 -> ack_err_o pulses 1 for exactly one cycle, state unchanged.
5. Two rising edges on req[7] with no ack -> ovf_o=0x80, pend_o=0x80. Ack idx 7 -> ovf_o=0x00, pend_o=0x00. en=0 plus an edge on req[1] -> pend_o unchanged.
6. Hold req=0xFF through a reset pulse and release -> pend_o stays 0x00. Drop and re-raise req[4] -> pend_o=0x10. Assert rst_n=0 mid-stream -> all outputs 0 immediately, before the next clock edge.
